// File: rtl/regfile_arb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package regfile_arb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DROP_W     = 8;

    typedef enum logic [1:0] {
        SRC_CORE = 2'd0,
        SRC_AUX0 = 2'd1,
        SRC_AUX1 = 2'd2,
        SRC_NONE = 2'd3
    } src_e;

    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } aux_entry_t;

endpackage

// File: rtl/regfile_aux_fifo.sv
// Auxiliary write queue: registered ready, live-flagged entries, and a kill port that
// retires every queued (or incoming) entry aimed at a given register.
module regfile_aux_fifo
    import regfile_arb_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  push_en,
    input  logic [REG_ADDR_W-1:0] push_reg,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop_en,
    input  logic                  kill_en,
    input  logic [REG_ADDR_W-1:0] kill_reg,
    output logic                  ready,
    output logic                  head_valid,
    output logic                  head_live,
    output logic [REG_ADDR_W-1:0] head_reg,
    output logic [DATA_W-1:0]     head_data
);

    localparam int unsigned PtrW = $clog2(Depth);

    aux_entry_t        mem_q [Depth];
    aux_entry_t        mem_d [Depth];
    logic [PtrW:0]     wptr_q, wptr_d, rptr_q, rptr_d, occ;
    logic              ready_q, ready_d;
    logic              do_push, do_pop;

    always_comb begin
        mem_d   = mem_q;
        occ     = wptr_q - rptr_q;
        do_push = push_en && ready_q;
        do_pop  = pop_en && (occ != '0);
        for (int i = 0; i < int'(Depth); i++) begin
            if (kill_en && (mem_q[i].addr == kill_reg)) begin
                mem_d[i].live = 1'b0;
            end
        end
        if (do_push) begin
            mem_d[wptr_q[PtrW-1:0]].live = (push_reg != '0) &&
                                           !(kill_en && (kill_reg == push_reg));
            mem_d[wptr_q[PtrW-1:0]].addr = push_reg;
            mem_d[wptr_q[PtrW-1:0]].data = push_data;
        end
        wptr_d  = wptr_q + (PtrW+1)'(do_push);
        rptr_d  = rptr_q + (PtrW+1)'(do_pop);
        // This cycle's pop is deliberately ignored: space freed now is offered next cycle.
        ready_d = (occ + (PtrW+1)'(do_push)) < (PtrW+1)'(Depth);
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign ready      = ready_q;
    assign head_valid = (occ != '0);
    assign head_live  = mem_q[rptr_q[PtrW-1:0]].live;
    assign head_reg   = mem_q[rptr_q[PtrW-1:0]].addr;
    assign head_data  = mem_q[rptr_q[PtrW-1:0]].data;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between core writeback (priority) and two buffered
// auxiliary requesters with round-robin, starvation stall and core-write supersede.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  core_stall,
    input  logic                  aux0_valid,
    output logic                  aux0_ready,
    input  logic [REG_ADDR_W-1:0] aux0_reg,
    input  logic [DATA_W-1:0]     aux0_data,
    input  logic                  aux1_valid,
    output logic                  aux1_ready,
    input  logic [REG_ADDR_W-1:0] aux1_reg,
    input  logic [DATA_W-1:0]     aux1_data,
    output logic                  ctrl_writeEnable,
    output logic [REG_ADDR_W-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0]     data_writeReg,
    output logic [DROP_W-1:0]     drop_count
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

    logic [1:0]            head_valid, head_live, live, dead, pop;
    logic [REG_ADDR_W-1:0] head_reg0, head_reg1;
    logic [DATA_W-1:0]     head_data0, head_data1;
    logic                  kill_en;
    src_e                  aux_pick, grant;

    logic                  we_q, we_d, stall_q, stall_d, rr_q, rr_d;
    logic [REG_ADDR_W-1:0] reg_q, reg_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DROP_W-1:0]     drop_q, drop_d;
    logic [DROP_W:0]       drop_sum;

    regfile_aux_fifo #(.Depth(FIFO_DEPTH)) u_fifo0 (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .push_en    (aux0_valid),
        .push_reg   (aux0_reg),
        .push_data  (aux0_data),
        .pop_en     (pop[0]),
        .kill_en    (kill_en),
        .kill_reg   (wb_reg),
        .ready      (aux0_ready),
        .head_valid (head_valid[0]),
        .head_live  (head_live[0]),
        .head_reg   (head_reg0),
        .head_data  (head_data0)
    );

    regfile_aux_fifo #(.Depth(FIFO_DEPTH)) u_fifo1 (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .push_en    (aux1_valid),
        .push_reg   (aux1_reg),
        .push_data  (aux1_data),
        .pop_en     (pop[1]),
        .kill_en    (kill_en),
        .kill_reg   (wb_reg),
        .ready      (aux1_ready),
        .head_valid (head_valid[1]),
        .head_live  (head_live[1]),
        .head_reg   (head_reg1),
        .head_data  (head_data1)
    );

    always_comb begin
        live = head_valid & head_live;
        dead = head_valid & ~head_live;

        if (live == 2'b11)   aux_pick = rr_q ? SRC_AUX1 : SRC_AUX0;
        else if (live[0])    aux_pick = SRC_AUX0;
        else if (live[1])    aux_pick = SRC_AUX1;
        else                 aux_pick = SRC_NONE;

        if (stall_q)         grant = aux_pick;
        else if (wb_en)      grant = SRC_CORE;
        else                 grant = aux_pick;

        kill_en = (grant == SRC_CORE) && (wb_reg != '0);
        pop[0]  = dead[0] || (grant == SRC_AUX0);
        pop[1]  = dead[1] || (grant == SRC_AUX1);

        we_d   = 1'b1;
        reg_d  = '0;
        data_d = '0;
        unique case (grant)
            SRC_CORE: begin reg_d = wb_reg;    data_d = wb_data;    end
            SRC_AUX0: begin reg_d = head_reg0; data_d = head_data0; end
            SRC_AUX1: begin reg_d = head_reg1; data_d = head_data1; end
            default:  we_d = 1'b0;
        endcase

        rr_d = ((grant == SRC_AUX0) || (grant == SRC_AUX1)) ? ~rr_q : rr_q;

        drop_sum = {1'b0, drop_q} + (DROP_W+1)'(dead[0]) + (DROP_W+1)'(dead[1]);
        drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];

        // Count core grants that bypass a live auxiliary head; anything else resets it.
        stall_d = 1'b0;
        cnt_d   = '0;
        if ((grant == SRC_CORE) && (live != 2'b00)) begin
            if (cnt_q + CntW'(1) == StarveMax) stall_d = 1'b1;
            else                               cnt_d   = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            we_q    <= 1'b0;
            reg_q   <= '0;
            data_q  <= '0;
            stall_q <= 1'b0;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            drop_q  <= '0;
        end else begin
            we_q    <= we_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            stall_q <= stall_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    assign core_stall       = stall_q;
    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = reg_q;
    assign data_writeReg    = data_q;
    assign drop_count       = drop_q;

endmodule
